game_session_ctrl: RTL and testbench
====================================

// Module: game_session_ctrl
// PURPOSE
//  Session sequencer for the reaction game. Holds the game in reset until the player presses
//  start, then runs ROUNDS reaction rounds and tallies correct answers (game code 10) and wrong
//  answers (game code 11). Afterwards it shows the hit count on the shared digit for SCORE_HOLD
//  cycles. Sits between the top-level button/7-seg glue and the reaction game instance.
// PARAMETERS
//  ROUNDS      5           rounds per session; legal range 1..9, so the score fits one digit
//  SCORE_HOLD  20_000_000  cycles the final score is shown before returning to IDLE
//  TIMEOUT     30_000_000  cycles a target may stay unanswered (only with SESSION_TIMEOUT_EN)
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous reset, active low
//  start       in   1  start button, level, already synchronised; acted on at its rising edge
//  game_value  in   4  game output: 0 = wait, 1..4 = target, 10 = right, 11 = wrong
//  game_rst    out  1  active-high reset to the game instance
//  disp_value  out  4  digit code to the display driver
//  round_cnt   out  4  number of completed rounds in the current session
//  busy        out  1  high in PLAY and SCORE
//  done        out  1  one-cycle pulse at the SCORE -> IDLE transition
// BEHAVIOUR
//  Reset values (async, rst_n=0): state=IDLE, game_rst=1, disp_value=0, round_cnt=0, hits=0,
//   busy=0, done=0; the edge-detect registers clear to 0, so start held low->high after reset
//   counts as an edge.
//  All outputs are registered, so each takes effect one cycle after the causing input.
//  IDLE : game_rst=1, disp_value=0.
//   - start rising edge -> PLAY; round_cnt=0, hits=0, game_rst=0.
//  PLAY : disp_value=game_value (pass-through, registered).
//   - A result event is the cycle where game_value is in {10,11} and was not in {10,11} on
//     the previous cycle. It is detected once per result, whatever the hold length.
//   - On each event: round_cnt+1; hits+1 if game_value==10.
//   - If the event brings round_cnt to ROUNDS: go to SCORE in the same cycle, using the
//     updated hits, and set game_rst=1.
//   - start edges are ignored.
//   - Codes 5..9 and 12..15 on game_value are passed through and never count as events.
//  SCORE: game_rst=1, disp_value=hits, hold counter runs 0..SCORE_HOLD-1.
//   - On the terminal count -> IDLE; done=1 for exactly one cycle; round_cnt and hits are
//     kept until the next start.
//   - start edges are ignored.
//  Widths: hits and round_cnt are 4 bits and saturate at ROUNDS (no wrap).
//   Hold/timeout counters are 25 bits and cleared on every state entry.
//  Reset mid-session: session aborted immediately, all outputs at reset values, no done pulse.
// CONFIGURATION
//  Macro SESSION_TIMEOUT_EN.
//  - Defined: in PLAY, a timer counts while game_value is in 1..4 and clears otherwise.
//    Reaching TIMEOUT counts as a miss (round_cnt+1, hits unchanged) and pulses game_rst for
//    one cycle, so the game restarts its random wait. This miss reaches SCORE exactly like
//    a normal result event.
//  - Undefined: no timer logic; the session waits indefinitely for an answer.
// STRUCTURE
//  Shared package game_pkg:
//  - display codes CODE_BLANK=4'd0, CODE_RIGHT=4'd10, CODE_WRONG=4'd11
//  - session state encoding IDLE=2'b00, PLAY=2'b01, SCORE=2'b10; 2'b11 recovers to IDLE
//  One sub-module, edge_rise: registered rising-edge detector, reused for start and for the
//   result flag.
//  Rest of the block: one state register process plus one combinational next-state process.
// TESTING (bench uses ROUNDS=3, SCORE_HOLD=8, TIMEOUT=16, with a behavioural game model)
//  1 reset, start held 0 -> game_rst=1, disp_value=0, busy=0 for 20 cycles.
//  2 start edge; results 10,11,10 (each held 5 cycles) -> hits=2, round_cnt=3; SCORE shows
//    disp_value=2 for 8 cycles; done pulses once; back in IDLE, game_rst=1.
//  3 start edge while in PLAY and while in SCORE -> no state change, counters unchanged.
//  4 rst_n low for 1 cycle after round 2 -> all outputs at reset values; next start begins
//    with round_cnt=0.
//  5 result code held 40 cycles -> counted once; codes 7 and 15 injected -> no count,
//    passed through to disp_value.
//  6 SESSION_TIMEOUT_EN defined: target 3 held 16 cycles -> miss counted, game_rst high for
//    1 cycle. Undefined: the same stimulus leaves round_cnt=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared codes, session state encoding and small helpers for the reaction game session logic.
package game_pkg;

   localparam logic [3:0] CODE_BLANK = 4'd0;
   localparam logic [3:0] CODE_RIGHT = 4'd10;
   localparam logic [3:0] CODE_WRONG = 4'd11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PLAY  = 2'b01,
      SCORE = 2'b10
   } state_t;

   function automatic logic is_result(input logic [3:0] code);
      return (code == CODE_RIGHT) || (code == CODE_WRONG);
   endfunction

   // Counters stop at the session length instead of wrapping.
   function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] lim);
      return (val >= lim) ? lim : val + 4'd1;
   endfunction

endpackage

// File: rtl/game_session_ctrl_edge_rise.sv
// Rising-edge detector: remembers last cycle's level and flags a low-to-high change.
module edge_rise (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic rise
);

   logic level_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) level_d <= 1'b0;
      else        level_d <= level;
   end

   assign rise = level & ~level_d;

endmodule

// File: rtl/game_session_ctrl.sv
// Session sequencer for the reaction game: start -> ROUNDS rounds -> score display -> idle.
// Optional unanswered-target timeout is built in when SESSION_TIMEOUT_EN is defined.
module game_session_ctrl
   import game_pkg::*;
#(
   parameter int ROUNDS     = 5,
   parameter int SCORE_HOLD = 20_000_000,
   parameter int TIMEOUT    = 30_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] game_value,
   output logic       game_rst,
   output logic [3:0] disp_value,
   output logic [3:0] round_cnt,
   output logic       busy,
   output logic       done
);

   localparam logic [3:0]  ROUNDS_L  = 4'(ROUNDS);
   localparam logic [24:0] HOLD_LAST = 25'(SCORE_HOLD - 1);

   state_t      state, state_nxt;
   logic        game_rst_nxt, busy_nxt, done_nxt;
   logic [3:0]  disp_nxt, round_nxt, hits, hits_nxt;
   logic [24:0] hold_cnt, hold_nxt;
   logic        start_rise, result_flag, result_rise, miss;

   assign result_flag = is_result(game_value);

   edge_rise u_start_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .level (start),
      .rise  (start_rise)
   );

   edge_rise u_result_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .level (result_flag),
      .rise  (result_rise)
   );

`ifdef SESSION_TIMEOUT_EN
   localparam logic [24:0] TIMEOUT_LAST = 25'(TIMEOUT - 1);

   logic [24:0] timer, timer_nxt;
   logic        target;

   assign target = (game_value >= 4'd1) && (game_value <= 4'd4);
   assign miss   = (state == PLAY) && target && (timer == TIMEOUT_LAST);

   // Timer only runs while a target is shown; any other code or state clears it.
   always_comb begin
      timer_nxt = '0;
      if ((state == PLAY) && target && !miss) timer_nxt = timer + 25'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) timer <= '0;
      else        timer <= timer_nxt;
   end
`else
   assign miss = 1'b0;
`endif

   always_comb begin
      state_nxt    = state;
      game_rst_nxt = game_rst;
      disp_nxt     = disp_value;
      round_nxt    = round_cnt;
      hits_nxt     = hits;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      hold_nxt     = '0;
      case (state)
         IDLE: begin
            game_rst_nxt = 1'b1;
            disp_nxt     = CODE_BLANK;
            busy_nxt     = 1'b0;
            if (start_rise) begin
               state_nxt    = PLAY;
               round_nxt    = 4'd0;
               hits_nxt     = 4'd0;
               game_rst_nxt = 1'b0;
               busy_nxt     = 1'b1;
            end
         end
         PLAY: begin
            busy_nxt     = 1'b1;
            game_rst_nxt = miss;
            disp_nxt     = game_value;
            if (result_rise || miss) begin
               round_nxt = sat_inc(round_cnt, ROUNDS_L);
               if (result_rise && (game_value == CODE_RIGHT))
                  hits_nxt = sat_inc(hits, ROUNDS_L);
               // Final round goes straight to the score using the updated tally.
               if (round_nxt == ROUNDS_L) begin
                  state_nxt    = SCORE;
                  game_rst_nxt = 1'b1;
                  disp_nxt     = hits_nxt;
               end
            end
         end
         SCORE: begin
            game_rst_nxt = 1'b1;
            busy_nxt     = 1'b1;
            disp_nxt     = hits;
            hold_nxt     = hold_cnt + 25'd1;
            if (hold_cnt == HOLD_LAST) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               disp_nxt  = CODE_BLANK;
               hold_nxt  = '0;
            end
         end
         default: begin
            state_nxt    = IDLE;
            game_rst_nxt = 1'b1;
            disp_nxt     = CODE_BLANK;
            busy_nxt     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         game_rst   <= 1'b1;
         disp_value <= CODE_BLANK;
         round_cnt  <= 4'd0;
         hits       <= 4'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         hold_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         game_rst   <= game_rst_nxt;
         disp_value <= disp_nxt;
         round_cnt  <= round_nxt;
         hits       <= hits_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         hold_cnt   <= hold_nxt;
      end
   end

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed bench for game_session_ctrl with a game model that outputs 0 while held in reset.
module tb_game_session_ctrl;

   localparam int ROUNDS     = 3;
   localparam int SCORE_HOLD = 8;
   localparam int TIMEOUT    = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] stim = 4'd0;
   logic [3:0] game_value;
   logic       game_rst;
   logic [3:0] disp_value;
   logic [3:0] round_cnt;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   assign game_value = game_rst ? 4'd0 : stim;

   game_session_ctrl #(
      .ROUNDS     (ROUNDS),
      .SCORE_HOLD (SCORE_HOLD),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .game_value (game_value),
      .game_rst   (game_rst),
      .disp_value (disp_value),
      .round_cnt  (round_cnt),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic play_result(input logic [3:0] code, input int hold);
      stim = code;
      repeat (hold) step();
      stim = 4'd0;
      repeat (3) step();
   endtask

   task automatic wait_done(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (done === 1'b1) begin
            seen = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      stim  = 4'd0;
      repeat (3) step();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (game_rst !== 1'b1 || disp_value !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle cyc %0d: game_rst=%b disp=%0d busy=%b, want 1 0 0",
                     i, game_rst, disp_value, busy);
         end
      end
      checks++;
      if (round_cnt !== 4'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_counts: round_cnt=%0d done=%b, want 0 0", round_cnt, done);
      end
   endtask

   task automatic test_session;
      int done_count;
      do_start();
      checks++;
      if (busy !== 1'b1 || game_rst !== 1'b0 || round_cnt !== 4'd0) begin
         errors++;
         $display("FAIL session_start: busy=%b game_rst=%b round=%0d, want 1 0 0",
                  busy, game_rst, round_cnt);
      end
      stim = 4'd10;
      step();
      checks++;
      if (disp_value !== 4'd10) begin
         errors++;
         $display("FAIL session_passthru: disp=%0d, want 10", disp_value);
      end
      repeat (4) step();
      stim = 4'd0;
      repeat (3) step();
      checks++;
      if (round_cnt !== 4'd1) begin
         errors++;
         $display("FAIL session_round1: round=%0d, want 1", round_cnt);
      end
      play_result(4'd11, 5);
      checks++;
      if (round_cnt !== 4'd2 || disp_value !== 4'd0) begin
         errors++;
         $display("FAIL session_round2: round=%0d disp=%0d, want 2 0", round_cnt, disp_value);
      end
      stim = 4'd10;
      step();
      stim = 4'd0;
      checks++;
      if (round_cnt !== 4'd3 || disp_value !== 4'd2 || game_rst !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL session_score_entry: round=%0d disp=%0d game_rst=%b busy=%b, want 3 2 1 1",
                  round_cnt, disp_value, game_rst, busy);
      end
      done_count = 0;
      for (int i = 1; i < SCORE_HOLD; i++) begin
         step();
         if (done === 1'b1) done_count++;
         checks++;
         if (disp_value !== 4'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL session_score_hold cyc %0d: disp=%0d busy=%b, want 2 1",
                     i, disp_value, busy);
         end
      end
      step();
      if (done === 1'b1) done_count++;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || disp_value !== 4'd0 || game_rst !== 1'b1
          || round_cnt !== 4'd3) begin
         errors++;
         $display("FAIL session_end: done=%b busy=%b disp=%0d game_rst=%b round=%0d, want 1 0 0 1 3",
                  done, busy, disp_value, game_rst, round_cnt);
      end
      repeat (3) begin
         step();
         if (done === 1'b1) done_count++;
      end
      checks++;
      if (done_count !== 1) begin
         errors++;
         $display("FAIL session_done_once: pulses=%0d, want 1", done_count);
      end
   endtask

   task automatic test_ignore_start;
      bit seen;
      do_start();
      play_result(4'd10, 5);
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || game_rst !== 1'b0 || round_cnt !== 4'd1) begin
         errors++;
         $display("FAIL start_in_play: busy=%b game_rst=%b round=%0d, want 1 0 1",
                  busy, game_rst, round_cnt);
      end
      step();
      play_result(4'd11, 5);
      stim = 4'd11;
      step();
      stim  = 4'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || disp_value !== 4'd1 || round_cnt !== 4'd3 || done !== 1'b0) begin
         errors++;
         $display("FAIL start_in_score: busy=%b disp=%0d round=%0d done=%b, want 1 1 3 0",
                  busy, disp_value, round_cnt, done);
      end
      wait_done(20, seen);
      checks++;
      if (seen !== 1'b1) begin
         errors++;
         $display("FAIL start_in_score_done: done seen=%b, want 1", seen);
      end
      step();
      checks++;
      if (busy !== 1'b0 || round_cnt !== 4'd3 || game_rst !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_keeps_round: busy=%b round=%0d game_rst=%b done=%b, want 0 3 1 0",
                  busy, round_cnt, game_rst, done);
      end
   endtask

   task automatic test_reset_mid;
      bit seen;
      int stray;
      do_start();
      play_result(4'd10, 5);
      play_result(4'd10, 5);
      checks++;
      if (round_cnt !== 4'd2) begin
         errors++;
         $display("FAIL midrst_pre: round=%0d, want 2", round_cnt);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (game_rst !== 1'b1 || disp_value !== 4'd0 || round_cnt !== 4'd0 || busy !== 1'b0
          || done !== 1'b0) begin
         errors++;
         $display("FAIL midrst_outputs: game_rst=%b disp=%0d round=%0d busy=%b done=%b, want 1 0 0 0 0",
                  game_rst, disp_value, round_cnt, busy, done);
      end
      step();
      rst_n = 1'b1;
      stray = 0;
      repeat (12) begin
         step();
         if (done !== 1'b0 || busy !== 1'b0) stray++;
      end
      checks++;
      if (stray !== 0) begin
         errors++;
         $display("FAIL midrst_quiet: stray cycles=%0d, want 0", stray);
      end
      do_start();
      checks++;
      if (round_cnt !== 4'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midrst_restart: round=%0d busy=%b, want 0 1", round_cnt, busy);
      end
      play_result(4'd11, 3);
      play_result(4'd11, 3);
      stim = 4'd11;
      step();
      stim = 4'd0;
      checks++;
      if (disp_value !== 4'd0 || busy !== 1'b1 || round_cnt !== 4'd3) begin
         errors++;
         $display("FAIL midrst_score: disp=%0d busy=%b round=%0d, want 0 1 3",
                  disp_value, busy, round_cnt);
      end
      wait_done(20, seen);
      checks++;
      if (seen !== 1'b1) begin
         errors++;
         $display("FAIL midrst_done: done seen=%b, want 1", seen);
      end
   endtask

   task automatic test_hold_and_codes;
      bit seen;
      do_start();
      play_result(4'd10, 40);
      checks++;
      if (round_cnt !== 4'd1) begin
         errors++;
         $display("FAIL long_hold: round=%0d, want 1", round_cnt);
      end
      stim = 4'd7;
      step();
      checks++;
      if (disp_value !== 4'd7) begin
         errors++;
         $display("FAIL code7_passthru: disp=%0d, want 7", disp_value);
      end
      step();
      stim = 4'd15;
      step();
      checks++;
      if (disp_value !== 4'd15 || round_cnt !== 4'd1) begin
         errors++;
         $display("FAIL code15: disp=%0d round=%0d, want 15 1", disp_value, round_cnt);
      end
      stim = 4'd0;
      step();
      play_result(4'd11, 5);
      checks++;
      if (round_cnt !== 4'd2) begin
         errors++;
         $display("FAIL codes_round2: round=%0d, want 2", round_cnt);
      end
      stim = 4'd10;
      step();
      stim = 4'd0;
      checks++;
      if (disp_value !== 4'd2 || round_cnt !== 4'd3) begin
         errors++;
         $display("FAIL codes_score: disp=%0d round=%0d, want 2 3", disp_value, round_cnt);
      end
      wait_done(20, seen);
      checks++;
      if (seen !== 1'b1) begin
         errors++;
         $display("FAIL codes_done: done seen=%b, want 1", seen);
      end
   endtask

   task automatic test_timeout;
      int early;
      do_start();
      stim  = 4'd3;
      early = 0;
      for (int k = 1; k <= TIMEOUT; k++) begin
         step();
         if (k == 1) begin
            checks++;
            if (disp_value !== 4'd3) begin
               errors++;
               $display("FAIL target_passthru: disp=%0d, want 3", disp_value);
            end
         end
         if (k < TIMEOUT && game_rst !== 1'b0) early++;
      end
      checks++;
      if (early !== 0) begin
         errors++;
         $display("FAIL timeout_early: game_rst high cycles=%0d, want 0", early);
      end
`ifdef SESSION_TIMEOUT_EN
      checks++;
      if (game_rst !== 1'b1 || round_cnt !== 4'd1) begin
         errors++;
         $display("FAIL timeout_miss: game_rst=%b round=%0d, want 1 1", game_rst, round_cnt);
      end
`else
      checks++;
      if (game_rst !== 1'b0 || round_cnt !== 4'd0) begin
         errors++;
         $display("FAIL no_timeout: game_rst=%b round=%0d, want 0 0", game_rst, round_cnt);
      end
`endif
      stim = 4'd0;
      step();
      checks++;
`ifdef SESSION_TIMEOUT_EN
      if (game_rst !== 1'b0 || round_cnt !== 4'd1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout_pulse_end: game_rst=%b round=%0d busy=%b, want 0 1 1",
                  game_rst, round_cnt, busy);
      end
`else
      if (game_rst !== 1'b0 || round_cnt !== 4'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL no_timeout_after: game_rst=%b round=%0d busy=%b, want 0 0 1",
                  game_rst, round_cnt, busy);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_session();
      test_ignore_start();
      test_reset_mid();
      test_hold_and_codes();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
